// File: rtl/alu_issue_stage.sv
// ID/EX stage feeding the ALU: decode, operand forwarding, load-use stall.
// Ports: decode-side valid/ready + instr/pc/rf data, fwd1/fwd2 bypass, ALU-side valid/ready + operands/op/rd.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [31:0]     pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd1_valid,
  input  logic            fwd1_pending,
  input  logic [4:0]      fwd1_rd,
  input  logic [XLEN-1:0] fwd1_data,
  input  logic            fwd2_valid,
  input  logic [4:0]      fwd2_rd,
  input  logic [XLEN-1:0] fwd2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] store_data,
  output logic [31:0]     pc_out,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_fld;

  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign rd_fld  = instr[11:7];

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};

  logic is_op, is_opi, is_lui, is_auipc;
  logic is_jal, is_jalr, is_load, is_store, is_br;

  assign is_op    = opc == OPC_OP;
  assign is_opi   = opc == OPC_OPIMM;
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_load  = opc == OPC_LOAD;
  assign is_store = opc == OPC_STORE;
  assign is_br    = opc == OPC_BRANCH;

  // fwd1 is the nearer producer, so it is checked first
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;

  always_comb begin
    src1 = rs1_data;
    if (rs1_idx == 5'd0)
      src1 = '0;
    else if (fwd1_valid && fwd1_rd == rs1_idx)
      src1 = fwd1_data;
    else if (fwd2_valid && fwd2_rd == rs1_idx)
      src1 = fwd2_data;
  end

  always_comb begin
    src2 = rs2_data;
    if (rs2_idx == 5'd0)
      src2 = '0;
    else if (fwd1_valid && fwd1_rd == rs2_idx)
      src2 = fwd1_data;
    else if (fwd2_valid && fwd2_rd == rs2_idx)
      src2 = fwd2_data;
  end

  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic [3:0]      d_op;
  logic [4:0]      d_rd;
  logic            d_ill;
  logic            use1;
  logic            use2;

  always_comb begin
    d_a   = '0;
    d_b   = '0;
    d_op  = 4'd0;
    d_rd  = 5'd0;
    d_ill = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    unique case (1'b1)
      is_op: begin
        d_a  = src1;
        d_b  = src2;
        d_op = {instr[30], f3};
        d_rd = rd_fld;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      is_opi: begin
        d_a  = src1;
        d_b  = imm_i;
        // only SRAI carries a funct7 bit; ADDI's bit 30 is immediate
        d_op = {instr[30] & (f3 == 3'd5), f3};
        d_rd = rd_fld;
        use1 = 1'b1;
      end
      is_lui: begin
        d_b  = imm_u;
        d_rd = rd_fld;
      end
      is_auipc: begin
        d_a  = XLEN'(pc);
        d_b  = imm_u;
        d_rd = rd_fld;
      end
      is_jal: begin
        d_a  = XLEN'(pc);
        d_b  = XLEN'(4);
        d_rd = rd_fld;
      end
      is_jalr: begin
        d_a  = XLEN'(pc);
        d_b  = XLEN'(4);
        d_rd = rd_fld;
        use1 = 1'b1;
      end
      is_load: begin
        d_a  = src1;
        d_b  = imm_i;
        d_rd = rd_fld;
        use1 = 1'b1;
      end
      is_store: begin
        d_a  = src1;
        d_b  = imm_s;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      is_br: begin
        d_a  = src1;
        d_b  = src2;
        use1 = 1'b1;
        use2 = 1'b1;
        unique case (f3)
          3'd0, 3'd1: d_op = 4'b1000;
          3'd4, 3'd5: d_op = 4'b0010;
          3'd6, 3'd7: d_op = 4'b0011;
          default:    d_op = 4'b0000;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
  end

  logic stall;

  assign stall = fwd1_valid & fwd1_pending & (fwd1_rd != 5'd0)
               & ((use1 & (fwd1_rd == rs1_idx))
               |  (use2 & (fwd1_rd == rs2_idx)));

  assign in_ready = (~out_valid | out_ready) & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      operand_a  <= '0;
      operand_b  <= '0;
      alu_op     <= 4'd0;
      rd         <= 5'd0;
      store_data <= '0;
      pc_out     <= 32'd0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid  <= 1'b1;
      operand_a  <= d_a;
      operand_b  <= d_b;
      alu_op     <= d_op;
      rd         <= d_rd;
      store_data <= src2;
      pc_out     <= pc;
      illegal    <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
